// File: rtl/accel_loader_pkg.sv
// Shared types and address-map helpers for the ai_accel stream loader.
// The helpers derive the window geometry from the same parameters the accelerator uses.
package accel_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RADDR,
        S_RCAP,
        S_ROUT
    } state_t;

    // Bus words per N x N matrix.
    function automatic int calc_m(input int n, input int width);
        return (n * n) / width;
    endfunction

    // Address bytes covered by one bus word.
    function automatic int calc_step(input int bits, input int width);
        return (width * bits) / 8;
    endfunction

    // Base of the C window: directly after the A and B windows.
    function automatic int calc_c_off(input int offcet, input int n, input int bits,
                                      input int width);
        return offcet + 2 * calc_m(n, width) * calc_step(bits, width);
    endfunction

endpackage

// File: rtl/accel_loader.sv
// Streams A then B into the accelerator's write windows, waits for both stored
// flags, then reads the C window back out as a valid/ready stream.
//
// Handshakes: a word moves on the input port when in_valid && in_ready at a
// rising edge, and on the output port when out_valid && out_ready at a rising
// edge; out_valid never drops and out_data never changes until that happens.
module accel_loader
    import accel_loader_pkg::*;
#(
    parameter int                    BITS       = 8,
    parameter int                    N          = 8,
    parameter int                    WIDTH      = 4,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] OFFCET     = 10'd128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*BITS-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*BITS-1:0]   out_data,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   acc_addr,
    output logic                    acc_wr_en,
    output logic [WIDTH*BITS-1:0]   acc_wdata,
    input  logic [WIDTH*BITS-1:0]   acc_rdata,
    input  logic                    acc_a_stored,
    input  logic                    acc_b_stored,
    input  logic                    acc_c_show
);

    localparam int M     = calc_m(N, WIDTH);
    localparam int STEP  = calc_step(BITS, WIDTH);
    localparam int C_OFF = calc_c_off(int'(OFFCET), N, BITS, WIDTH);
    localparam int DW    = WIDTH * BITS;
    localparam int IDX_W = $clog2(2 * M);

    localparam logic [ADDR_WIDTH-1:0] STEP_A    = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] C_OFF_A   = ADDR_WIDTH'(C_OFF);
    localparam logic [IDX_W-1:0]      LAST_LOAD = IDX_W'(2 * M - 1);
    localparam logic [IDX_W-1:0]      LAST_C    = IDX_W'(M - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);

    // The last C address must fit in the address bus without wrapping.
    if (C_OFF + (M - 1) * STEP >= (1 << ADDR_WIDTH)) begin : g_addr_range_check
        $error("accel_loader: C window exceeds ADDR_WIDTH address space");
    end

    state_t                  state, state_d;
    logic [IDX_W-1:0]        idx, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DW-1:0]           wdata_d, odata_d;
    logic                    wr_en_d, ovalid_d, done_d, err_d;

    assign in_ready = (state == S_LOAD);

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        addr_d   = acc_addr;
        wdata_d  = acc_wdata;
        wr_en_d  = 1'b0;
        odata_d  = out_data;
        ovalid_d = out_valid;
        done_d   = 1'b0;
        err_d    = err;
        case (state)
            S_IDLE: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
            S_LOAD: begin
                if (in_valid) begin
                    addr_d  = OFFCET + ADDR_WIDTH'(idx) * STEP_A;
                    wdata_d = in_data;
                    wr_en_d = 1'b1;
                    if (idx == LAST_LOAD) begin
                        idx_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        idx_d = idx + IDX_ONE;
                    end
                end
            end
            S_WAIT: begin
                // The final B write is still in flight while acc_wr_en is high.
                if (acc_a_stored && acc_b_stored && !acc_wr_en) begin
                    state_d = S_RADDR;
                end
            end
            S_RADDR: begin
                addr_d  = C_OFF_A + ADDR_WIDTH'(idx) * STEP_A;
                state_d = S_RCAP;
            end
            S_RCAP: begin
                odata_d  = acc_rdata;
                ovalid_d = 1'b1;
                if (!acc_c_show) begin
                    err_d = 1'b1;
                end
                state_d = S_ROUT;
            end
            S_ROUT: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    if (idx == LAST_C) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        idx_d   = idx + IDX_ONE;
                        state_d = S_RADDR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_wr_en <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            acc_addr  <= addr_d;
            acc_wdata <= wdata_d;
            acc_wr_en <= wr_en_d;
            out_data  <= odata_d;
            out_valid <= ovalid_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_accel_loader.sv
// Directed bench for accel_loader: a small accelerator stub plus a matrix-level
// model that predicts every write, every C word, done, err and in_ready.
module tb_accel_loader;

    localparam int BITS = 8, N = 8, WIDTH = 4, ADDR_WIDTH = 10;
    localparam int DW = WIDTH * BITS, M = N * N / WIDTH, STEP = DW / 8;
    localparam int OFFCET = 128, C_OFF = OFFCET + 2 * M * STEP;

    typedef logic [DW-1:0] mat_t [2*M];

    logic                  clk, rst;
    logic                  in_valid, in_ready, out_valid, out_ready, done, err;
    logic [DW-1:0]         in_data, out_data, acc_wdata, acc_rdata;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_wr_en, acc_a_stored, acc_b_stored, acc_c_show;

    accel_loader #(
        .BITS(BITS), .N(N), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .OFFCET(10'd128)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .err(err),
        .acc_addr(acc_addr), .acc_wr_en(acc_wr_en), .acc_wdata(acc_wdata),
        .acc_rdata(acc_rdata), .acc_a_stored(acc_a_stored),
        .acc_b_stored(acc_b_stored), .acc_c_show(acc_c_show)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // C = A * B over row-major packed words, each element truncated to BITS.
    function automatic logic [DW-1:0] c_word(input mat_t m, input int w);
        logic [DW-1:0] res;
        res = '0;
        for (int l = 0; l < WIDTH; l++) begin
            int e, r, c, sum;
            logic [DW-1:0] aw, bw;
            e = w * WIDTH + l; r = e / N; c = e % N; sum = 0;
            for (int k = 0; k < N; k++) begin
                int ea, eb;
                ea = r * N + k; eb = k * N + c;
                aw = m[ea / WIDTH]; bw = m[M + eb / WIDTH];
                sum += int'(aw[(ea % WIDTH) * BITS +: BITS]) * int'(bw[(eb % WIDTH) * BITS +: BITS]);
            end
            res[l * BITS +: BITS] = sum[BITS-1:0];
        end
        return res;
    endfunction

    // ---------------- accelerator stub ----------------
    mat_t          stub_mem;
    logic [DW-1:0] stub_c [M];
    int            a_cnt = 0, b_cnt = 0, force_b_low = 0;
    bit            drop_c7 = 1'b0;
    int            rd_off;

    always @(posedge clk) begin
        if (acc_wr_en) begin
            int ix;
            ix = (int'(acc_addr) - OFFCET) / STEP;
            if (ix >= 0 && ix < 2 * M) begin
                stub_mem[ix] <= acc_wdata;
                if (ix == 0) begin
                    a_cnt <= 1; b_cnt <= 0;
                end else if (ix < M) begin
                    a_cnt <= a_cnt + 1;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int w = 0; w < M; w++) stub_c[w] = c_word(stub_mem, w);
    end

    assign acc_a_stored = (a_cnt == M);
    assign acc_b_stored = (b_cnt == M) && (force_b_low == 0);
    assign acc_c_show   = !(drop_c7 && int'(acc_addr) == C_OFF + 7 * STEP);
    assign rd_off       = int'(acc_addr) - C_OFF;
    assign acc_rdata    = (rd_off >= 0 && rd_off < M * STEP) ? stub_c[rd_off / STEP] : '0;

    // ---------------- consumer (out_ready) ----------------
    int stall_word = -1, stall_left = 0, c_idx = 0;

    always @(posedge clk) begin
        #1;
        if (out_valid && stall_left > 0 && c_idx == stall_word) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    end

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0]          exp_q[$];
    logic [DW-1:0]          c_log[$];
    logic [ADDR_WIDTH-1:0]  c_addr_log[$];
    mat_t                   exp_mat;
    int   load_idx = 0, since = 0, held_cnt = 0, n_wr = 0;
    bit   rst_prev = 1'b1, loading = 1'b1, wr_pend = 1'b0, done_pend = 1'b0;
    bit   exp_err = 1'b0, hold_prev = 1'b0;
    int   pend_addr = 0, first_wr_addr = -1, last_wr_addr = -1;
    logic [DW-1:0] pend_data, prev_data;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_ctrl", {in_ready, out_valid, done, err, acc_wr_en, acc_addr}, '0);
            check("reset_data", {out_data, acc_wdata}, '0);
            exp_q.delete();
            load_idx = 0; c_idx = 0; loading = 1'b1; wr_pend = 1'b0; done_pend = 1'b0;
            exp_err = 1'b0; hold_prev = 1'b0; n_wr = 0; first_wr_addr = -1;
        end else begin
            since = rst_prev ? 0 : since + 1;
            check("in_ready", in_ready, loading && since >= 1);
            check("wr_en", acc_wr_en, wr_pend);
            if (wr_pend && acc_wr_en) begin
                check("wr_addr", acc_addr, pend_addr);
                check("wr_data", acc_wdata, pend_data);
                if (n_wr == 0) first_wr_addr = int'(acc_addr);
                last_wr_addr = int'(acc_addr);
                n_wr++;
            end
            check("done", done, done_pend);
            done_pend = 1'b0;
            if (drop_c7 && out_valid && c_idx == 7) exp_err = 1'b1;
            check("err", err, exp_err);
            if (hold_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
            end
            if (exp_q.size() == 0) begin
                check("no_result_pending", out_valid, 1'b0);
            end else if (out_valid) begin
                check("out_data", out_data, exp_q[0]);
                check("rd_addr", acc_addr, C_OFF + c_idx * STEP);
                if (out_ready) begin
                    c_log.push_back(out_data);
                    c_addr_log.push_back(acc_addr);
                    void'(exp_q.pop_front());
                    c_idx++;
                    if (c_idx == M) begin
                        c_idx = 0; done_pend = 1'b1; loading = 1'b1;
                    end
                end
            end
            if (force_b_low > 0) begin
                check("no_read_while_waiting", int'(acc_addr) >= C_OFF || out_valid, 1'b0);
                force_b_low--;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            if (hold_prev) held_cnt++;
            wr_pend = 1'b0;
            if (in_valid && in_ready) begin
                wr_pend = 1'b1;
                pend_addr = OFFCET + load_idx * STEP;
                pend_data = in_data;
                exp_mat[load_idx] = in_data;
                load_idx++;
                if (load_idx == 2 * M) begin
                    load_idx = 0; loading = 1'b0;
                    for (int w = 0; w < M; w++) exp_q.push_back(c_word(exp_mat, w));
                end
            end
        end
        rst_prev = rst;
    end

    // ---------------- driver tasks ----------------
    mat_t stim;

    task automatic build_count();
        for (int i = 0; i < 2 * M; i++) stim[i] = DW'(i);
    endtask

    task automatic build_ident(input logic [BITS-1:0] k);
        for (int w = 0; w < M; w++) begin
            logic [DW-1:0] aw;
            aw = '0;
            for (int l = 0; l < WIDTH; l++) begin
                int e;
                e = w * WIDTH + l;
                if (e / N == e % N) aw[l * BITS +: BITS] = 8'd1;
            end
            stim[w]     = aw;
            stim[M + w] = {WIDTH{k}};
        end
    endtask

    task automatic send(input int count);
        for (int i = 0; i < count; i++) begin
            bit ok;
            int guard;
            ok = 1'b0; guard = 0;
            in_valid = 1'b1;
            in_data  = stim[i];
            while (!ok && guard < 200) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            check("accept_timeout", ok, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        int guard;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 2000) begin
            @(negedge clk);
            seen = done;
            guard++;
        end
        check(name, seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        do_reset();

        // Counting words 0..31: write addresses, spacing and in_ready drop.
        build_count();
        c_log.delete(); c_addr_log.delete();
        send(2 * M);
        wait_done("seq1_done");
        check("first_wr_addr", first_wr_addr, 128);
        check("last_wr_addr", last_wr_addr, 252);
        check("first_rd_addr", c_addr_log[0], 256);
        check("last_rd_addr", c_addr_log[M-1], 316);

        // Identity A, B=5, with consumer stalling 5 cycles on C word 3.
        build_ident(8'd5);
        c_log.delete(); held_cnt = 0;
        stall_word = 3; stall_left = 5;
        send(2 * M);
        wait_done("seq2_done");
        check("c_word0_lit", c_log[0], 32'h05050505);
        check("c_word15_lit", c_log[M-1], 32'h05050505);
        check("stall_cycles", held_cnt, 5);
        stall_word = -1;

        // B stored flag held low for 20 cycles after load.
        begin
            int wait_cyc;
            build_ident(8'd9);
            c_log.delete();
            send(2 * M);
            force_b_low = 20;
            wait_cyc = 0;
            while (!out_valid && wait_cyc < 200) begin
                @(negedge clk);
                wait_cyc++;
            end
            check("b_wait_min_cycles", wait_cyc >= 21, 1'b1);
            wait_done("seq3_done");
            check("c_word7_k9_lit", c_log[7], 32'h09090909);
        end

        // c_show low while word 7 is captured; err must stick.
        build_count();
        drop_c7 = 1'b1;
        send(2 * M);
        wait_done("seq4_done");
        drop_c7 = 1'b0;
        check("err_set_lit", err, 1'b1);
        build_ident(8'd3);
        send(2 * M);
        wait_done("seq5_done");
        check("err_sticky_lit", err, 1'b1);

        // Reset after 10 words: immediate clear, then restart at A word 0.
        build_count();
        send(10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ctrl", {in_ready, out_valid, done, err, acc_wr_en, acc_addr}, '0);
        check("rst_async_data", {out_data, acc_wdata}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        build_ident(8'd7);
        send(2 * M);
        wait_done("seq6_done");
        check("restart_wr_addr", first_wr_addr, 128);
        check("err_after_reset", err, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
